fifo_blk_reader: RTL and testbench

Read-side consumer for the dual-clock FIFO. It sits in the read clock domain and pops DSIZE-bit words from the FIFO read port. It packs BLK_W/DSIZE consecutive words into one BLK_W-bit block (64-bit DES block by default) and presents that block downstream with a valid/ready handshake.

---
 rtl/fifo_rd_pkg.sv | 24 ++
 rtl/fifo_blk_reader.sv | 118 +++++++++++
 tb/tb_fifo_blk_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO read-side block packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_rd_pkg;

  // FSM encoding kept as plain constants so legacy code can compare raw bits.
  typedef logic [0:0] state_t;
  localparam state_t ST_FILL = 1'b0;  // collecting words
  localparam state_t ST_HOLD = 1'b1;  // block presented downstream

  // Default output block width: one 64-bit DES block.
  localparam int BLK_W_DEF = 64;

  // Number of FIFO words packed into one block.
  function automatic int beats_f(input int blk_w, input int dsize);
    return blk_w / dsize;
  endfunction

  // Width of a counter able to hold 0..beats inclusive.
  function automatic int cnt_w_f(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/fifo_blk_reader.sv
// Pops DSIZE-bit words from a dual-clock FIFO read port and packs BEATS of them into one BLK_W-bit block.
// Latency: blk_valid rises on the edge that captures the last word (1 cycle after the final rinc).
// Backpressure: while a block waits for blk_ready no words are popped; accept-cycle pop starts the next block.
//
// Ports:
//   rclk, rrst_n          read-domain clock, async active-low reset
//   rdata, rempty, rinc   FIFO read port (head word, empty flag, pop strobe)
//   blk_data, blk_valid,
//   blk_ready             packed block with valid/ready handshake
//   flush, blk_cnt        partial-block flush request and word count of blk_data
//                         (only when FIFO_RD_FLUSH_EN is defined)
module fifo_blk_reader
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int BLK_W = BLK_W_DEF,
  localparam int BEATS = beats_f(BLK_W, DSIZE),
  localparam int CW    = cnt_w_f(BEATS)
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  input  logic             blk_ready,
`ifdef FIFO_RD_FLUSH_EN
  input  logic             flush,
  output logic [CW-1:0]    blk_cnt,
`endif
  output logic             rinc,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid
);

  state_t           state;
  logic [CW-1:0]    beat_cnt;
  logic [BLK_W-1:0] sreg;
  logic [BLK_W-1:0] sreg_nxt;
  logic             last_beat;
  logic             fill_done;

  // Pop whenever a word is available and there is room: always while filling,
  // and in the accepting cycle while holding. Gated by reset so the FIFO never
  // sees a pop strobe while this side is held in reset.
  assign rinc = rrst_n && !rempty && ((state == ST_FILL) || blk_ready);

  // Big-endian packing: oldest word drifts toward the MSBs.
  assign sreg_nxt  = (sreg << DSIZE) | BLK_W'(rdata);
  assign last_beat = (beat_cnt == CW'(BEATS - 1));
  assign fill_done = (state == ST_FILL) && rinc && last_beat;

`ifdef FIFO_RD_FLUSH_EN
  logic [CW-1:0]    flush_words;
  logic             flush_take;
  logic [BLK_W-1:0] flush_blk;

  // A flush counts the word popped in the same cycle. A flush that lands on
  // the completing pop is left to the normal path so blk_cnt reads BEATS.
  assign flush_words = beat_cnt + CW'(rinc);
  assign flush_take  = flush && (state == ST_FILL) && (flush_words != '0) && !fill_done;
  // Left-align the partial block so beat 0 is still in the top word.
  assign flush_blk   = (rinc ? sreg_nxt : sreg) << (DSIZE * (BEATS - int'(flush_words)));
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= ST_FILL;
      beat_cnt  <= '0;
      sreg      <= '0;
      blk_data  <= '0;
      blk_valid <= 1'b0;
`ifdef FIFO_RD_FLUSH_EN
      blk_cnt   <= '0;
`endif
    end else begin
      if (rinc) begin
        sreg <= sreg_nxt;
      end
      case (state)
        ST_FILL: begin
          if (fill_done) begin
            state     <= ST_HOLD;
            blk_valid <= 1'b1;
            blk_data  <= sreg_nxt;
            beat_cnt  <= '0;
`ifdef FIFO_RD_FLUSH_EN
            blk_cnt   <= CW'(BEATS);
`endif
          end
`ifdef FIFO_RD_FLUSH_EN
          else if (flush_take) begin
            state     <= ST_HOLD;
            blk_valid <= 1'b1;
            blk_data  <= flush_blk;
            beat_cnt  <= '0;
            blk_cnt   <= flush_words;
          end
`endif
          else if (rinc) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          // blk_data is a separate register so it stays put while the shift
          // register already collects the next block.
          if (blk_ready) begin
            state     <= ST_FILL;
            blk_valid <= 1'b0;
            beat_cnt  <= CW'(rinc);
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_blk_reader.sv
// Self-checking bench for fifo_blk_reader with a queue-based FIFO and block model.
// Latency: n/a (testbench).
// Backpressure: driven directly via blk_ready and forced-empty gaps.
module tb_fifo_blk_reader;

  localparam int DSIZE = 8;
  localparam int BLK_W = 64;
  localparam int BEATS = BLK_W / DSIZE;
  localparam int CW    = $clog2(BEATS + 1);

  logic             rclk = 1'b0;
  logic             rrst_n = 1'b1;
  logic [DSIZE-1:0] rdata = '0;
  logic             rempty = 1'b1;
  logic             blk_ready = 1'b0;
  logic             rinc;
  logic [BLK_W-1:0] blk_data;
  logic             blk_valid;
`ifdef FIFO_RD_FLUSH_EN
  logic             flush = 1'b0;
  logic [CW-1:0]    blk_cnt;
`endif

  fifo_blk_reader #(.DSIZE(DSIZE), .BLK_W(BLK_W)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rdata     (rdata),
    .rempty    (rempty),
    .blk_ready (blk_ready),
`ifdef FIFO_RD_FLUSH_EN
    .flush     (flush),
    .blk_cnt   (blk_cnt),
`endif
    .rinc      (rinc),
    .blk_data  (blk_data),
    .blk_valid (blk_valid)
  );

  always #5 rclk = ~rclk;

  // Reference model: FIFO contents, words popped into the current block,
  // and the queue of blocks (with word counts) awaiting acceptance.
  logic [DSIZE-1:0] fq[$];
  logic [DSIZE-1:0] cur[$];
  logic [BLK_W-1:0] eq[$];
  int               ecq[$];
  logic             exp_valid = 1'b0;

  // Per-cycle stimulus knobs.
  logic force_empty = 1'b0;
  logic ready_sel   = 1'b1;
  logic flush_sel   = 1'b0;

  int checks   = 0;
  int failures = 0;
  int rinc_cnt = 0;
  int vld_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Build the expected block from the words in cur, left-aligned, zero padded.
  task automatic push_block(input int n);
    logic [BLK_W-1:0] b;
    b = '0;
    foreach (cur[i]) b = (b << DSIZE) | BLK_W'(cur[i]);
    b = b << ((BEATS - n) * DSIZE);
    eq.push_back(b);
    ecq.push_back(n);
    cur.delete();
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step();
    logic pop;
    logic nxt;
    rempty    = (fq.size() == 0) || force_empty;
    rdata     = rempty ? DSIZE'($urandom) : fq[0];
    blk_ready = ready_sel;
`ifdef FIFO_RD_FLUSH_EN
    flush     = flush_sel;
`endif
    #1;
    pop = !rempty && (!exp_valid || blk_ready);
    check("rinc", 64'(rinc), 64'(pop));
    check("blk_valid", 64'(blk_valid), 64'(exp_valid));
    if (exp_valid && eq.size() != 0) begin
      check("blk_data", blk_data, eq[0]);
`ifdef FIFO_RD_FLUSH_EN
      check("blk_cnt", 64'(blk_cnt), 64'(ecq[0]));
`endif
    end
    if (rinc) rinc_cnt++;
    if (blk_valid) vld_cnt++;
    nxt = exp_valid && !blk_ready;
    if (exp_valid && blk_ready && eq.size() != 0) begin
      void'(eq.pop_front());
      void'(ecq.pop_front());
    end
    if (pop) cur.push_back(fq.pop_front());
    if (cur.size() == BEATS) begin
      push_block(BEATS);
      nxt = 1'b1;
    end
`ifdef FIFO_RD_FLUSH_EN
    else if (flush_sel && !exp_valid && cur.size() > 0) begin
      push_block(cur.size());
      nxt = 1'b1;
    end
`endif
    exp_valid = nxt;
    @(posedge rclk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset asserted between edges; outputs checked while held with a word offered.
  task automatic do_reset();
    rrst_n    = 1'b0;
    rempty    = 1'b0;
    rdata     = 8'h5A;
    blk_ready = 1'b1;
`ifdef FIFO_RD_FLUSH_EN
    flush     = 1'b0;
`endif
    #2;
    check("rst_rinc", 64'(rinc), 64'd0);
    check("rst_blk_valid", 64'(blk_valid), 64'd0);
    check("rst_blk_data", blk_data, 64'd0);
`ifdef FIFO_RD_FLUSH_EN
    check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
`endif
    cur.delete();
    eq.delete();
    ecq.delete();
    exp_valid = 1'b0;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  task automatic clear_cnts();
    rinc_cnt = 0;
    vld_cnt  = 0;
  endtask

  initial begin
    do_reset();

    // Single block, continuous data, sink always ready.
    for (int i = 1; i <= 8; i++) fq.push_back(DSIZE'(i));
    clear_cnts();
    run(12);
    check("t1_rinc_cycles", 64'(rinc_cnt), 64'd8);
    check("t1_valid_cycles", 64'(vld_cnt), 64'd1);

    // Two blocks; first one stalled for 5 cycles after it appears.
    for (int i = 1; i <= 16; i++) fq.push_back(DSIZE'(i));
    ready_sel = 1'b0;
    for (int i = 0; i < 40 && !exp_valid; i++) step();
    check("t2_first_blk_seen", 64'(exp_valid), 64'd1);
    run(5);
    ready_sel = 1'b1;
    run(12);

    // Empty every other cycle; content must match the continuous case.
    for (int i = 1; i <= 8; i++) fq.push_back(DSIZE'(i));
    for (int i = 0; i < 24; i++) begin
      force_empty = i[0];
      step();
    end
    force_empty = 1'b0;
    run(2);

    // Reset after three words; the partial block must not leak out.
    for (int i = 0; i < 3; i++) fq.push_back(8'hC0 + DSIZE'(i));
    run(3);
    do_reset();
    for (int i = 0; i < 8; i++) fq.push_back(8'hAA + DSIZE'(i));
    clear_cnts();
    run(12);
    check("t4_valid_cycles", 64'(vld_cnt), 64'd1);

`ifdef FIFO_RD_FLUSH_EN
    // Partial block via flush, then a flush with nothing collected.
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    fq.push_back(8'h33);
    run(5);
    clear_cnts();
    flush_sel = 1'b1;
    step();
    flush_sel = 1'b0;
    run(3);
    check("flush_valid_cycles", 64'(vld_cnt), 64'd1);
    clear_cnts();
    flush_sel = 1'b1;
    step();
    flush_sel = 1'b0;
    run(3);
    check("flush_empty_valid_cycles", 64'(vld_cnt), 64'd0);
`endif

    // Randomised data, FIFO gaps and sink stalls.
    for (int i = 0; i < 40; i++) fq.push_back(DSIZE'($urandom));
    for (int i = 0; i < 800 && (fq.size() != 0 || exp_valid); i++) begin
      force_empty = ($urandom_range(0, 9) < 3);
      ready_sel   = ($urandom_range(0, 9) < 7);
`ifdef FIFO_RD_FLUSH_EN
      flush_sel   = ($urandom_range(0, 9) == 0);
`endif
      step();
    end
    force_empty = 1'b0;
    ready_sel   = 1'b1;
    flush_sel   = 1'b0;
    check("rand_drained", 64'(fq.size() == 0 && !exp_valid), 64'd1);
`ifdef FIFO_RD_FLUSH_EN
    flush_sel = 1'b1;
    step();
    flush_sel = 1'b0;
`endif
    run(3);

    // Back-to-back blocks: rinc never drops, one valid every 8 cycles.
    for (int i = 0; i < 32; i++) fq.push_back(DSIZE'($urandom));
    clear_cnts();
    run(32);
    check("b2b_rinc_cycles", 64'(rinc_cnt), 64'd32);
    check("b2b_valid_cycles", 64'(vld_cnt), 64'd3);
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
